// File: rtl/id_arbiter_pkg.sv
// rtl/id_arbiter_pkg.sv - shared encodings and ASCII classes for the identifier arbiter
package id_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } ctl_state_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      SL = 2'd1,
      SD = 2'd2,
      SE = 2'd3
   } rec_state_t;

   localparam logic [7:0] DIGIT_LO = 8'd48;
   localparam logic [7:0] DIGIT_HI = 8'd57;
   localparam logic [7:0] UPPER_LO = 8'd65;
   localparam logic [7:0] UPPER_HI = 8'd90;
   localparam logic [7:0] LOWER_LO = 8'd97;
   localparam logic [7:0] LOWER_HI = 8'd122;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= UPPER_LO) && (c <= UPPER_HI)) || ((c >= LOWER_LO) && (c <= LOWER_HI));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= DIGIT_LO) && (c <= DIGIT_HI);
   endfunction

endpackage

// File: rtl/id_match.sv
// rtl/id_match.sv - letters-then-digits recognizer shared by both requesters
module id_match
   import id_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] char,
   output logic       acc
);

   rec_state_t st, st_nxt;

   always_comb begin
      st_nxt = st;
      if (clr) begin
         st_nxt = S0;
      end else if (en) begin
         case (st)
            S0:      st_nxt = is_letter(char) ? SL : SE;
            SL:      st_nxt = is_letter(char) ? SL : (is_digit(char) ? SD : SE);
            SD:      st_nxt = is_digit(char) ? SD : SE;
            default: st_nxt = SE;
         endcase
      end
   end

   // acc looks through the update so the caller sees the verdict on the character just taken
   assign acc = (st_nxt == SD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= S0;
      else       st <= st_nxt;
   end

endmodule

// File: rtl/id_arbiter.sv
// rtl/id_arbiter.sv - round-robin owner of one identifier recognizer between two requesters
module id_arbiter
   import id_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] char0,
   input  logic [7:0] char1,
   input  logic       last0,
   input  logic       last1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done,
   output logic       result,
   output logic       owner,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
);

   ctl_state_t state, state_nxt;
   logic       ptr;
   logic       win;
   logic       en;
   logic       clr;
   logic       lst;
   logic       finish;
   logic       acc;
   logic [7:0] ch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= 1'b1;
         done   <= 1'b0;
         result <= 1'b0;
         owner  <= 1'b0;
         cnt0   <= 8'd0;
         cnt1   <= 8'd0;
      end else begin
         state <= state_nxt;
         done  <= finish;
         if (finish) begin
            result <= acc;
            owner  <= (state == BUSY1);
            ptr    <= (state == BUSY1);
         end
         // counts trail done by one edge and saturate rather than wrap
         if (done && result) begin
            if (owner) cnt1 <= (cnt1 == 8'hFF) ? cnt1 : cnt1 + 8'd1;
            else       cnt0 <= (cnt0 == 8'hFF) ? cnt0 : cnt0 + 8'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      win       = (req0 && req1) ? ~ptr : req1;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = win ? BUSY1 : BUSY0;
         BUSY0:   if (req0 && last0) state_nxt = IDLE;
         BUSY1:   if (req1 && last1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt0   = (state == BUSY0);
      gnt1   = (state == BUSY1);
      en     = (gnt0 && req0) || (gnt1 && req1);
      ch     = gnt1 ? char1 : char0;
      lst    = gnt1 ? last1 : last0;
      finish = en && lst;
      clr    = (state == IDLE);
   end

   id_match u_match (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .char  (ch),
      .acc   (acc)
   );

endmodule

// File: tb/tb_id_arbiter.sv
// tb/tb_id_arbiter.sv - randomized and directed self-checking bench for id_arbiter
module tb_id_arbiter;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, last0, last1;
   logic [7:0] char0, char1;
   logic       gnt0, gnt1, done, result, owner;
   logic [7:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;

   id_arbiter dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .char0  (char0),
      .char1  (char1),
      .last0  (last0),
      .last1  (last1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .done   (done),
      .result (result),
      .owner  (owner),
      .cnt0   (cnt0),
      .cnt1   (cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bit is_ident(input bq_t q);
      int nl = 0;
      int nd = 0;
      while (nl < q.size() && ((q[nl] >= 65 && q[nl] <= 90) || (q[nl] >= 97 && q[nl] <= 122))) nl++;
      while (nl + nd < q.size() && q[nl+nd] >= 48 && q[nl+nd] <= 57) nd++;
      return (nl > 0) && (nd > 0) && (nl + nd == q.size());
   endfunction

   function automatic logic [7:0] rand_char(input int cls);
      logic [7:0] oth [9] = '{8'd45, 8'd95, 8'd32, 8'd64, 8'd91, 8'd96, 8'd123, 8'd47, 8'd58};
      if (cls == 0) return $urandom_range(0, 1) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(97, 122));
      if (cls == 1) return 8'($urandom_range(48, 57));
      return oth[$urandom_range(0, 8)];
   endfunction

   function automatic bq_t rand_str();
      bq_t q;
      if ($urandom_range(0, 1) == 1) begin
         int nl = $urandom_range(1, 3);
         int nd = $urandom_range(0, 3);
         for (int i = 0; i < nl; i++) q.push_back(rand_char(0));
         for (int i = 0; i < nd; i++) q.push_back(rand_char(1));
      end else begin
         int len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            int r = $urandom_range(0, 9);
            q.push_back(rand_char(r < 5 ? 0 : (r < 9 ? 1 : 2)));
         end
      end
      return q;
   endfunction

   task automatic drive(input int who, input logic r, input logic [7:0] c, input logic l);
      if (who == 0) begin req0 = r; char0 = c; last0 = l; end
      else          begin req1 = r; char1 = c; last1 = l; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 1'b0, 8'd0, 1'b0);
      drive(1, 1'b0, 8'd0, 1'b0);
      @(posedge clk); #1;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_owner", owner, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      reset = 1'b0;
   endtask

   // Runs one string on requester `who`, optionally pausing req before character stall_at.
   task automatic send(input int who, input bq_t s, input int stall_at, input int stall_len);
      int  idx = 0;
      int  cyc = 0;
      bit  fin = 0;
      logic g;
      bit  expr = is_ident(s);
      drive(who, 1'b1, s[0], s.size() == 1);
      while (!fin && cyc < 200) begin
         g = (who == 1) ? gnt1 : gnt0;
         @(posedge clk); #1;
         cyc++;
         check("mutex", gnt0 & gnt1, 0);
         if (g) begin
            if (idx == s.size() - 1) begin
               check("done", done, 1);
               check("result", result, expr);
               check("owner", owner, who);
               check("gnt_release", gnt0 | gnt1, 0);
               fin = 1;
            end else begin
               check("early_done", done, 0);
               idx++;
               if (idx == stall_at) begin
                  for (int k = 0; k < stall_len; k++) begin
                     drive(who, 1'b0, s[idx], 1'b0);
                     @(posedge clk); #1;
                     check("stall_gnt", (who == 1) ? gnt1 : gnt0, 1);
                     check("stall_done", done, 0);
                  end
               end
               drive(who, 1'b1, s[idx], idx == s.size() - 1);
            end
         end
      end
      if (!fin) check("timeout", 0, 1);
      drive(who, 1'b0, 8'd0, 1'b0);
      if (fin && expr) begin
         if (who == 0) exp_cnt0 = (exp_cnt0 < 255) ? exp_cnt0 + 1 : 255;
         else          exp_cnt1 = (exp_cnt1 < 255) ? exp_cnt1 + 1 : 255;
      end
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("cnt0", cnt0, exp_cnt0);
      check("cnt1", cnt1, exp_cnt1);
   endtask

   initial begin
      do_reset();

      send(0, s2q("abcd1234"), 0, 0);
      send(1, s2q("ab3c"), 0, 0);
      send(1, s2q("-"), 0, 0);
      send(0, s2q("a"), 0, 0);
      send(1, s2q("Zz09"), 0, 0);
      send(0, s2q("ab12"), 2, 3);

      // simultaneous "a1" from both requesters right after reset
      do_reset();
      drive(0, 1'b1, 8'd97, 1'b0);
      drive(1, 1'b1, 8'd97, 1'b0);
      @(posedge clk); #1;
      check("rr_gnt0_first", gnt0, 1);
      check("rr_gnt1_wait", gnt1, 0);
      @(posedge clk); #1;
      drive(0, 1'b1, 8'd49, 1'b1);
      @(posedge clk); #1;
      check("rr_done0", done, 1);
      check("rr_owner0", owner, 0);
      check("rr_result0", result, 1);
      check("rr_idle_gap", gnt0 | gnt1, 0);
      drive(0, 1'b0, 8'd0, 1'b0);
      @(posedge clk); #1;
      check("rr_gnt1", gnt1, 1);
      check("rr_done_low", done, 0);
      check("rr_cnt0", cnt0, 1);
      @(posedge clk); #1;
      drive(1, 1'b1, 8'd49, 1'b1);
      @(posedge clk); #1;
      check("rr_done1", done, 1);
      check("rr_owner1", owner, 1);
      check("rr_result1", result, 1);
      drive(1, 1'b0, 8'd0, 1'b0);
      @(posedge clk); #1;
      check("rr_cnt1", cnt1, 1);

      // reset in the middle of "abc1"
      drive(0, 1'b1, 8'd97, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(0, 1'b1, 8'd98, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b1, 8'd99, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_gnt0", gnt0, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_cnt0", cnt0, 0);
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 1'b0, 8'd0, 1'b0);
      @(posedge clk); #1;
      check("mid_rst_no_done", done, 0);
      send(0, s2q("x9"), 0, 0);

      for (int n = 0; n < 40; n++) begin
         bq_t s = rand_str();
         send(int'($urandom_range(0, 1)), s, int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
      end

      do_reset();
      for (int n = 0; n < 256; n++) send(0, s2q("a1"), 0, 0);
      check("sat_cnt0", cnt0, 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_arbiter.md
ID_ARBITER -- requirements
Module: id_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 req0, req1  input  1 each  requester i has a character valid this cycle.
REQ-004 char0, char1  input  8 each  ASCII character from requester i.
REQ-005 last0, last1  input  1 each  marks the final character of requester i's string; qualified by req_i.
REQ-006 gnt0, gnt1  output  1 each  registered; requester i owns the shared recognizer; never both high.
REQ-007 done  output  1  registered one-cycle pulse: a string has finished.
REQ-008 result  output  1  registered; valid with done; 1 = string is an identifier.
REQ-009 owner  output  1  registered; index of the requester whose string produced done.
REQ-010 cnt0, cnt1  output  8 each  count of accepted identifiers per requester.

Function
REQ-011 Identifier SHALL mean one or more letters (65-90, 97-122) followed by one or more digits (48-57), nothing else.
REQ-012 Controller states SHALL be IDLE, BUSY0 and BUSY1; gnt0 = (state==BUSY0) and gnt1 = (state==BUSY1).
REQ-013 IDLE, any req asserted: next state BUSY of the winner; recognizer cleared to start in the same edge.
REQ-014 Arbitration SHALL be round-robin on a 1-bit last-served pointer; if both request, the one not served last wins; if one requests, it wins.
REQ-015 After reset the pointer SHALL equal 1, so requester 0 wins the first simultaneous contest.
REQ-016 In BUSYi, a character SHALL be consumed exactly in cycles where req_i=1; the other requester is ignored.
REQ-017 In BUSYi with req_i=0, the controller SHALL stall, holding the grant and recognizer state.
REQ-018 On consuming a character with last_i=1: next state IDLE, done=1, owner=i, and result = recognizer accepting after that character; pointer := i.
REQ-019 Single-character string (last on first character) SHALL complete with result=0.
REQ-020 IDLE SHALL last at least one cycle between grants; back-to-back grants are not allowed.
REQ-021 done SHALL be high for exactly one cycle per string; result and owner hold their values until the next done.
REQ-022 cnt_i SHALL increment by 1 when done=1, owner=i and result=1, saturating at 255.
REQ-023 Recognizer states SHALL be S0, SL (letters), SD (digits, accepting) and SE (error).
REQ-024 Recognizer transitions SHALL be:
- S0: letter→SL, other→SE.
- SL: letter→SL, digit→SD, other→SE.
- SD: digit→SD, other→SE.
- SE: sticky until cleared.
REQ-025 Latency SHALL be as follows: the character with last is accepted at edge N; done, result, owner and gnt=0 appear after edge N; cnt updates after edge N+1.

Reset
REQ-026 Reset SHALL force state IDLE, recognizer S0, pointer 1, and gnt0, gnt1, done, result, owner, cnt0, cnt1 to 0.
REQ-027 Reset mid-string SHALL abandon the string: no done, no count change; the requester must restart.

Structure
REQ-028 A shared package SHALL hold the controller and recognizer state encodings and the ASCII range constants (48, 57, 65, 90, 97, 122).
REQ-029 The recognizer SHALL be a sub-module id_match (ports: clk, reset, clr, en, char, acc), instantiated once.

Verification
REQ-030 req0 stream 97,98,99,100,49,50,51,52 with last on 52 -> done=1, result=1, owner=0, cnt0=1.
REQ-031 req1 stream 97,98,51,99 (last on 99) -> result=0, cnt1 unchanged; stream 45 alone -> result=0.
REQ-032 req0 and req1 both high from reset, 2-char strings "a1" -> gnt0 first, one IDLE cycle, then gnt1; two done pulses, owners 0 then 1.
REQ-033 req0 drops for 3 cycles mid "ab12" -> gnt0 held, no consumption, result=1 after resume.
REQ-034 reset asserted after 2 chars of "abc1" -> gnt0=0 immediately, no done, cnt0=0; new string "x9" then gives result=1.
REQ-035 256 accepted "a1" strings from requester 0 -> cnt0 stops at 255.
